instruction_decoder: RTL and testbench
======================================

# instruction_decoder

Front-end producer for the instruction queue. Accepts a stream of 32-bit instruction words from the fetch buffer and reassembles variable-length instructions: one base word, plus two extension words when the instruction carries a 48-bit address. Drives the decoded field bus (major/minor opcode, sources, destination, offset controls, address) into the instruction queue. Holds each instruction stable while the queue's stall is high, so the queue never samples a partial or duplicated instruction.

## Interface
- Parameters: none. All widths are fixed by the instruction format in the shared package.
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- Flush_in  in  1  synchronous flush: discards any partial instruction and any pending output
- Word_in  in  32  instruction word from the fetch buffer
- WordValid_in  in  1  Word_in is valid this cycle
- WordReady_out  out  1  decoder accepts Word_in this cycle
- stall_in  in  1  queue full; the output instruction is not taken this cycle
- Valid_out  out  1  decoded instruction present on the field outputs
- MajorOpcode_out  out  4; Source1_out  out  5; Source2_out  out  5; OffsetScale_out  out  2; Destination_out  out  5; MinorOpcode_out  out  4; HasAddress_out  out  1; Address_out  out  48; OffsetSub_out  out  1  decoded fields
- Illegal_out  out  1  one-cycle pulse when a malformed instruction is dropped (only with the macro below)
- InstrCount_out  out  16  count of instructions handed to the queue, wraps at 2^16

## Operation
- Base word layout:
  - [31:28] major, [27:23] src1, [22:18] src2, [17:16] scale, [15:11] dest
  - [10:7] minor, [6] has_address, [5] offset_sub, [4:0] reserved
- Extension words:
  - ADDR_LO word carries Address[31:0].
  - ADDR_HI word carries Address[47:32] in bits [15:0]; bits [31:16] are reserved.
- Word transfer: a word is taken on a posedge when WordValid_in && WordReady_out.
- Output transfer: an instruction is taken on a posedge when Valid_out && !stall_in.
- States and transitions:
  - BASE --base word, has_address=0--> completes, stays in BASE.
  - BASE --base word, has_address=1--> ADDR_LO.
  - ADDR_LO --word--> ADDR_HI.
  - ADDR_HI --word--> completes, back to BASE.
- Assembly registers are separate from the output register.
- WordReady_out = (state==ADDR_LO) || !Valid_out || !stall_in. Completion is only possible into a free output register, or one being freed in the same cycle.
- On completion, the output register loads all fields and Valid_out=1.
  - When has_address=0, Address_out=0 and HasAddress_out=0.
- Fields and Valid_out hold unchanged while Valid_out && stall_in.
- InstrCount_out increments on each output transfer.
- Priority: reset > Flush_in > normal operation.
  - Flush clears the state to BASE and clears Valid_out.
  - Flush leaves InstrCount_out unchanged.
  - A word presented during a flush cycle is not accepted (WordReady_out=0 while Flush_in=1).
- Reset mid-instruction discards the partial assembly; no instruction is emitted.

## Timing
- Reset values:
  - Valid_out=0, Illegal_out=0, InstrCount_out=0, state=BASE
  - All field outputs 0; WordReady_out=1 after reset.
- Latency: fields valid on the cycle after the completing word is accepted.
  - Short form: 1 cycle after the base word.
  - Long form: 3 words, best case 3 consecutive cycles.
- Throughput: one short instruction per cycle with the queue not stalled, including back-to-back transfers with simultaneous load and unload.
- stall_in high for N cycles: exactly one transfer occurs, on the first cycle stall_in is low.
- WordValid_in low in ADDR_LO or ADDR_HI: the decoder waits indefinitely with no timeout.

## Configuration
- IDEC_ILLEGAL_CHECK_EN defined:
  - A base word with reserved [4:0] nonzero, or an ADDR_HI word with [31:16] nonzero, is malformed.
  - The complete malformed instruction is consumed but not emitted.
  - Illegal_out pulses for 1 cycle on the completing posedge.
  - InstrCount_out is unchanged.
- Macro undefined:
  - Reserved bits are ignored and every instruction is emitted.
  - Illegal_out is tied to 0.

## Structure
- Shared package instruction_pkg holds:
  - field widths and base-word bit positions
  - the 75-bit packed instruction struct, in the order major, src1, src2, scale, dest, minor, has_address, address, offset_sub (the queue's storage format)
  - the decoder state enum {BASE, ADDR_LO, ADDR_HI}
- One sub-module, instruction_field_extract: combinational base-word slicer plus reserved-bit check, reused later by the branch predecessor stage.

## Test plan
- Short form: base 0x329E4D20, stall_in=0 → next cycle Valid_out=1, major=3, src1=5, src2=7, scale=2, dest=9, minor=0xA, HasAddress=0, OffsetSub=1, Address=0; InstrCount_out=1.
- Long form: words 0x00000040, 0xDEADBEEF, 0x0000CAFE on consecutive cycles → Valid_out=1 one cycle after the third word; Address_out=0xCAFEDEADBEEF, HasAddress_out=1.
- Stall: stall_in=1 for 4 cycles with Valid_out=1 and the next word waiting → fields stable, WordReady_out=0 for those cycles, one transfer on release, next instruction loaded the same posedge.
- Flush in ADDR_HI, then base 0x329E4D20 → no long-form instruction emitted; short instruction emitted; InstrCount_out +1 only.
- Reset asserted mid-stream with Valid_out=1 → all outputs return to reset values the next cycle; stream restarts cleanly from BASE.
- With IDEC_ILLEGAL_CHECK_EN: base 0x329E4D21 → Illegal_out pulses once, Valid_out stays 0, InstrCount_out unchanged.

Source files
------------

// File: rtl/instruction_pkg.sv
// Shared instruction format: field widths, base-word bit positions, the packed
// instruction record used as queue storage, and the decoder state encoding.
package instruction_pkg;

  localparam int WORD_W   = 32;
  localparam int MAJOR_W  = 4;
  localparam int REG_W    = 5;
  localparam int SCALE_W  = 2;
  localparam int MINOR_W  = 4;
  localparam int ADDR_W   = 48;
  localparam int COUNT_W  = 16;

  localparam int MAJOR_LSB      = 28;
  localparam int SRC1_LSB       = 23;
  localparam int SRC2_LSB       = 18;
  localparam int SCALE_LSB      = 16;
  localparam int DEST_LSB       = 11;
  localparam int MINOR_LSB      = 7;
  localparam int HAS_ADDR_BIT   = 6;
  localparam int OFFSET_SUB_BIT = 5;
  localparam int RSVD_MSB       = 4;

  typedef struct packed {
    logic [MAJOR_W-1:0] major;
    logic [REG_W-1:0]   src1;
    logic [REG_W-1:0]   src2;
    logic [SCALE_W-1:0] scale;
    logic [REG_W-1:0]   dest;
    logic [MINOR_W-1:0] minor;
    logic               has_address;
    logic [ADDR_W-1:0]  address;
    logic               offset_sub;
  } instr_t;

  typedef enum logic [1:0] {
    BASE    = 2'd0,
    ADDR_LO = 2'd1,
    ADDR_HI = 2'd2
  } dec_state_e;

endpackage

// File: rtl/instruction_field_extract.sv
// Combinational base-word slicer: splits a base word into instruction fields
// (address left zero) and flags nonzero reserved bits.
module instruction_field_extract
  import instruction_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output instr_t            fields,
  output logic              rsvd_bad
);

  always_comb begin
    fields             = '0;
    fields.major       = word[MAJOR_LSB +: MAJOR_W];
    fields.src1        = word[SRC1_LSB +: REG_W];
    fields.src2        = word[SRC2_LSB +: REG_W];
    fields.scale       = word[SCALE_LSB +: SCALE_W];
    fields.dest        = word[DEST_LSB +: REG_W];
    fields.minor       = word[MINOR_LSB +: MINOR_W];
    fields.has_address = word[HAS_ADDR_BIT];
    fields.offset_sub  = word[OFFSET_SUB_BIT];
    rsvd_bad           = |word[RSVD_MSB:0];
  end

endmodule

// File: rtl/instruction_decoder.sv
// Reassembles 1- or 3-word instructions from the fetch stream into a held output
// register for the instruction queue. Define IDEC_ILLEGAL_CHECK_EN to drop malformed ones.
module instruction_decoder
  import instruction_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                Flush_in,
  input  logic [WORD_W-1:0]   Word_in,
  input  logic                WordValid_in,
  output logic                WordReady_out,
  input  logic                stall_in,
  output logic                Valid_out,
  output logic [MAJOR_W-1:0]  MajorOpcode_out,
  output logic [REG_W-1:0]    Source1_out,
  output logic [REG_W-1:0]    Source2_out,
  output logic [SCALE_W-1:0]  OffsetScale_out,
  output logic [REG_W-1:0]    Destination_out,
  output logic [MINOR_W-1:0]  MinorOpcode_out,
  output logic                HasAddress_out,
  output logic [ADDR_W-1:0]   Address_out,
  output logic                OffsetSub_out,
  output logic                Illegal_out,
  output logic [COUNT_W-1:0]  InstrCount_out
);

  dec_state_e         state_p0, state_nxt;
  instr_t             base_f, asm_p0, done_instr, out_p1;
  logic [WORD_W-1:0]  addr_lo_p0;
  logic               asm_bad_p0, rsvd_bad;
  logic               vld_p1, illegal_p1;
  logic [COUNT_W-1:0] count_p1;
  logic               out_free, xfer, take, complete, bad_done, drop;

  instruction_field_extract u_extract (
    .word     (Word_in),
    .fields   (base_f),
    .rsvd_bad (rsvd_bad)
  );

  assign out_free      = !vld_p1 || !stall_in;
  assign xfer          = vld_p1 && !stall_in;
  // ADDR_LO never completes, so it can accept even while the output is blocked.
  assign WordReady_out = !Flush_in && ((state_p0 == ADDR_LO) || out_free);
  assign take          = WordValid_in && WordReady_out;

  always_comb begin
    state_nxt  = state_p0;
    complete   = 1'b0;
    bad_done   = 1'b0;
    done_instr = base_f;
    case (state_p0)
      BASE: if (take) begin
        if (base_f.has_address) begin
          state_nxt = ADDR_LO;
        end else begin
          complete = 1'b1;
          bad_done = rsvd_bad;
        end
      end
      ADDR_LO: if (take) state_nxt = ADDR_HI;
      ADDR_HI: if (take) begin
        state_nxt          = BASE;
        complete           = 1'b1;
        bad_done           = asm_bad_p0 || (|Word_in[WORD_W-1:16]);
        done_instr         = asm_p0;
        done_instr.address = {Word_in[15:0], addr_lo_p0};
      end
      default: state_nxt = BASE;
    endcase
  end

`ifdef IDEC_ILLEGAL_CHECK_EN
  assign drop = bad_done;
`else
  logic unused_bad_done;
  assign drop            = 1'b0;
  assign unused_bad_done = bad_done;
`endif

  // Stage p0: assembly registers for the base word and low address word
  always_ff @(posedge clk) begin
    if (take && state_p0 == BASE) begin
      asm_p0     <= base_f;
      asm_bad_p0 <= rsvd_bad;
    end
    if (take && state_p0 == ADDR_LO) addr_lo_p0 <= Word_in;
  end

  // Stage p1: output register held while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0   <= BASE;
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      count_p1   <= '0;
      out_p1     <= '0;
    end else if (Flush_in) begin
      state_p0   <= BASE;
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
    end else begin
      state_p0   <= state_nxt;
      illegal_p1 <= complete && drop;
      if (xfer) count_p1 <= count_p1 + 16'd1;
      if (complete && !drop) begin
        vld_p1 <= 1'b1;
        out_p1 <= done_instr;
      end else if (xfer) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign Valid_out       = vld_p1;
  assign MajorOpcode_out = out_p1.major;
  assign Source1_out     = out_p1.src1;
  assign Source2_out     = out_p1.src2;
  assign OffsetScale_out = out_p1.scale;
  assign Destination_out = out_p1.dest;
  assign MinorOpcode_out = out_p1.minor;
  assign HasAddress_out  = out_p1.has_address;
  assign Address_out     = out_p1.address;
  assign OffsetSub_out   = out_p1.offset_sub;
  assign Illegal_out     = illegal_p1;
  assign InstrCount_out  = count_p1;

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed table-driven bench for instruction_decoder, plus hand sequences for
// reset and malformed-instruction handling.
module tb_instruction_decoder;

  logic        clk = 1'b0;
  logic        reset, Flush_in, WordValid_in, stall_in;
  logic [31:0] Word_in;
  logic        WordReady_out, Valid_out, HasAddress_out, OffsetSub_out, Illegal_out;
  logic [3:0]  MajorOpcode_out, MinorOpcode_out;
  logic [4:0]  Source1_out, Source2_out, Destination_out;
  logic [1:0]  OffsetScale_out;
  logic [47:0] Address_out;
  logic [15:0] InstrCount_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instruction_decoder dut (
    .clk(clk), .reset(reset), .Flush_in(Flush_in), .Word_in(Word_in),
    .WordValid_in(WordValid_in), .WordReady_out(WordReady_out), .stall_in(stall_in),
    .Valid_out(Valid_out), .MajorOpcode_out(MajorOpcode_out), .Source1_out(Source1_out),
    .Source2_out(Source2_out), .OffsetScale_out(OffsetScale_out),
    .Destination_out(Destination_out), .MinorOpcode_out(MinorOpcode_out),
    .HasAddress_out(HasAddress_out), .Address_out(Address_out),
    .OffsetSub_out(OffsetSub_out), .Illegal_out(Illegal_out),
    .InstrCount_out(InstrCount_out)
  );

  typedef struct {
    logic [3:0]  major;
    logic [4:0]  src1, src2;
    logic [1:0]  scale;
    logic [4:0]  dest;
    logic [3:0]  minor;
    logic        has_addr;
    logic [47:0] addr;
    logic        offsub;
  } fld_t;

  typedef struct {
    logic [31:0] word;
    logic        wv, stall, flush;
    logic        e_ready, e_valid, chk_f;
    logic [15:0] e_count;
    fld_t        f;
  } vec_t;

  // 0x329E4D20 decoded by hand
  localparam fld_t SHORT = '{4'd3, 5'd5, 5'd7, 2'd2, 5'd9, 4'hA, 1'b0, 48'h0, 1'b1};
  // 0x00000040 / 0xDEADBEEF / 0x0000CAFE
  localparam fld_t LONG  = '{4'd0, 5'd0, 5'd0, 2'd0, 5'd0, 4'h0, 1'b1, 48'hCAFE_DEAD_BEEF, 1'b0};
  // 0x10000000
  localparam fld_t ONE   = '{4'd1, 5'd0, 5'd0, 2'd0, 5'd0, 4'h0, 1'b0, 48'h0, 1'b0};
  localparam fld_t ZERO  = '{4'd0, 5'd0, 5'd0, 2'd0, 5'd0, 4'h0, 1'b0, 48'h0, 1'b0};

  vec_t vecs[$];

  task automatic add(input logic [31:0] w, input logic wv, input logic st, input logic fl,
                     input logic rdy, input logic vld, input logic [15:0] cnt,
                     input logic chk, input fld_t f);
    vec_t v;
    v.word = w; v.wv = wv; v.stall = st; v.flush = fl;
    v.e_ready = rdy; v.e_valid = vld; v.e_count = cnt; v.chk_f = chk; v.f = f;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_fields(input string tag, input fld_t f);
    check({tag, ".major"},  64'(MajorOpcode_out), 64'(f.major));
    check({tag, ".src1"},   64'(Source1_out),     64'(f.src1));
    check({tag, ".src2"},   64'(Source2_out),     64'(f.src2));
    check({tag, ".scale"},  64'(OffsetScale_out), 64'(f.scale));
    check({tag, ".dest"},   64'(Destination_out), 64'(f.dest));
    check({tag, ".minor"},  64'(MinorOpcode_out), 64'(f.minor));
    check({tag, ".hasadr"}, 64'(HasAddress_out),  64'(f.has_addr));
    check({tag, ".addr"},   64'(Address_out),     64'(f.addr));
    check({tag, ".offsub"}, 64'(OffsetSub_out),   64'(f.offsub));
  endtask

  // Drive at negedge, check ready before the edge, outputs 1ns after it.
  task automatic step(input string tag, input logic [31:0] w, input logic wv, input logic st,
                      input logic fl, input logic rdy, input logic vld, input logic [15:0] cnt,
                      input logic ill, input logic chk, input fld_t f);
    @(negedge clk);
    Word_in = w; WordValid_in = wv; stall_in = st; Flush_in = fl;
    #1;
    check({tag, ".ready"}, 64'(WordReady_out), 64'(rdy));
    @(posedge clk);
    #1;
    check({tag, ".valid"},   64'(Valid_out),      64'(vld));
    check({tag, ".count"},   64'(InstrCount_out), 64'(cnt));
    check({tag, ".illegal"}, 64'(Illegal_out),    64'(ill));
    if (chk) check_fields(tag, f);
  endtask

  initial begin
    reset = 1'b1; Flush_in = 1'b0; WordValid_in = 1'b0; stall_in = 1'b0; Word_in = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check("rst.valid", 64'(Valid_out), 64'(0));
    check("rst.count", 64'(InstrCount_out), 64'(0));
    check("rst.illegal", 64'(Illegal_out), 64'(0));
    check("rst.ready", 64'(WordReady_out), 64'(1));
    check_fields("rst", ZERO);

    //   word          wv    st    fl    rdy   vld   cnt  chk  fields
    add(32'h329E4D20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b1, SHORT);
    add(32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0, ZERO);
    add(32'h00000040, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0, ZERO);
    add(32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0, ZERO);
    add(32'h0000CAFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, LONG);
    add(32'h329E4D20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 1'b1, SHORT);
    for (int i = 0; i < 4; i++)
      add(32'h10000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 1'b1, SHORT);
    add(32'h10000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, 1'b1, ONE);
    add(32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 1'b0, ZERO);
    add(32'h00000040, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 1'b0, ZERO);
    add(32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 1'b0, ZERO);
    add(32'h0000CAFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 1'b0, ZERO);
    add(32'h329E4D20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd4, 1'b1, SHORT);
    add(32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5, 1'b0, ZERO);
    add(32'h10000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd5, 1'b1, ONE);
    add(32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5, 1'b0, ZERO);
    add(32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5, 1'b0, ZERO);

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].word, vecs[i].wv, vecs[i].stall, vecs[i].flush,
           vecs[i].e_ready, vecs[i].e_valid, vecs[i].e_count, 1'b0, vecs[i].chk_f, vecs[i].f);

    // Reset while an instruction is pending on the output
    step("rs_load", 32'h329E4D20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd5, 1'b0, 1'b1, SHORT);
    @(negedge clk);
    reset = 1'b1; WordValid_in = 1'b0;
    @(posedge clk); #1;
    check("rs_v.valid", 64'(Valid_out), 64'(0));
    check("rs_v.count", 64'(InstrCount_out), 64'(0));
    check("rs_v.illegal", 64'(Illegal_out), 64'(0));
    check_fields("rs_v", ZERO);
    reset = 1'b0; stall_in = 1'b0;
    #1;
    check("rs_v.ready", 64'(WordReady_out), 64'(1));

    // Reset in ADDR_HI: the next word must be decoded as a fresh base word
    step("rs_lo", 32'h00000040, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, ZERO);
    step("rs_hi", 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, ZERO);
    @(negedge clk);
    reset = 1'b1; WordValid_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    step("rs_base", 32'h329E4D20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b1, SHORT);
    step("rs_idle", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 1'b0, ZERO);

`ifdef IDEC_ILLEGAL_CHECK_EN
    step("ill_b", 32'h329E4D21, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 1'b0, ZERO);
    step("ill_b2", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 1'b0, ZERO);
    step("ill_lo", 32'h00000040, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 1'b0, ZERO);
    step("ill_mid", 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 1'b0, ZERO);
    step("ill_hi", 32'h00010000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 1'b0, ZERO);
    step("ill_ok", 32'h329E4D20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 1'b1, SHORT);
    step("ill_end", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0, ZERO);
`else
    step("rsv_b", 32'h329E4D21, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 1'b1, SHORT);
    step("rsv_end", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0, ZERO);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
